// File: rtl/uart_tx_if.sv
// Request/status bundle between a byte producer and the UART transmitter.
//   start_uart   : transmit request (producer -> transmitter)
//   urt_tx_data  : byte to send, captured when the request is accepted
//   busy_uart    : frame in progress (transmitter -> producer)
//   tx_done      : one-enabled-cycle pulse at frame completion
interface uart_tx_if;

    logic       start_uart;
    logic [7:0] urt_tx_data;
    logic       busy_uart;
    logic       tx_done;

    // Producer side.
    modport master (
        output start_uart,
        output urt_tx_data,
        input  busy_uart,
        input  tx_done
    );

    // Transmitter side.
    modport slave (
        input  start_uart,
        input  urt_tx_data,
        output busy_uart,
        output tx_done
    );

endinterface

// File: rtl/uart_tx.sv
// Serial UART transmitter: start bit, 8 data bits LSB first, optional parity,
// one or two stop bits. All activity is qualified by clock_enable.
//   system_clock : sole clock, rising edge
//   rst          : asynchronous active-high reset
//   clock_enable : qualifies every register update
//   bus          : request/status bundle (start_uart, urt_tx_data, busy_uart, tx_done)
//   tx_serial    : serial line, idle high, driven straight from a flop
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic      system_clock,
    input  logic      rst,
    input  logic      clock_enable,
    uart_tx_if.slave  bus,
    output logic      tx_serial
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 8;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4
    } state_t;

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   baud_q,    baud_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [DATA_W-1:0]  tx_byte_q, tx_byte_d;
    logic               stop_q,    stop_d;
    logic               tx_q,      tx_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic               baud_term_c;
    logic               stop_last_c;
    logic               parity_bit_c;
    logic [IDX_W-1:0]   idx_next_c;
    logic [CNT_W-1:0]   baud_next_c;

    assign tx_serial     = tx_q;
    assign bus.busy_uart = busy_q;
    assign bus.tx_done   = done_q;

    // Bit-period bookkeeping shared by every non-idle state.
    assign baud_term_c  = (baud_q == BAUD_LAST);
    assign baud_next_c  = baud_term_c ? '0 : baud_q + CNT_W'(1);
    assign idx_next_c   = idx_q + IDX_W'(1);
    // Second stop bit only exists when two are configured.
    assign stop_last_c  = (STOP_BITS == 2) ? stop_q : 1'b1;
    assign parity_bit_c = (^tx_byte_q) ^ (PARITY_ODD != 0);

    // State and output registers.
    always_ff @(posedge system_clock or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            idx_q     <= '0;
            tx_byte_q <= '0;
            stop_q    <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            idx_q     <= idx_d;
            tx_byte_q <= tx_byte_d;
            stop_q    <= stop_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and next-output logic; everything holds while clock_enable is low.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        idx_d     = idx_q;
        tx_byte_d = tx_byte_q;
        stop_d    = stop_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = done_q;

        if (clock_enable) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                    baud_d = '0;
                    idx_d  = '0;
                    stop_d = 1'b0;
                    if (bus.start_uart) begin
                        // Start bit goes out on the accepting edge itself.
                        tx_byte_d = bus.urt_tx_data;
                        busy_d    = 1'b1;
                        tx_d      = 1'b0;
                        state_d   = START_BIT;
                    end
                end

                START_BIT: begin
                    baud_d = baud_next_c;
                    if (baud_term_c) begin
                        idx_d   = '0;
                        tx_d    = tx_byte_q[0];
                        state_d = DATA;
                    end
                end

                DATA: begin
                    baud_d = baud_next_c;
                    if (baud_term_c) begin
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            if (PARITY_EN != 0) begin
                                tx_d    = parity_bit_c;
                                state_d = PARITY;
                            end else begin
                                tx_d    = 1'b1;
                                stop_d  = 1'b0;
                                state_d = STOP;
                            end
                        end else begin
                            idx_d = idx_next_c;
                            tx_d  = tx_byte_q[idx_next_c];
                        end
                    end
                end

                PARITY: begin
                    baud_d = baud_next_c;
                    if (baud_term_c) begin
                        tx_d    = 1'b1;
                        stop_d  = 1'b0;
                        state_d = STOP;
                    end
                end

                STOP: begin
                    baud_d = baud_next_c;
                    tx_d   = 1'b1;
                    if (baud_term_c) begin
                        if (stop_last_c) begin
                            stop_d  = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            stop_d = 1'b1;
                        end
                    end
                end

                default: begin
                    // Unused encodings recover to a clean idle line.
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    baud_d  = '0;
                    idx_d   = '0;
                    stop_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover the parameter variants
// (plain, even parity, odd parity, two stop bits), all with CLKS_PER_BIT=4.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       system_clock = 1'b0;
    logic       rst;
    logic       ce;
    logic       ce_toggle;
    logic       start;
    logic [7:0] data;
    int         sel;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic tx_a, tx_b, tx_c, tx_d;
    logic tx_m, busy_m, done_m;

    uart_tx_if if_a ();
    uart_tx_if if_b ();
    uart_tx_if if_c ();
    uart_tx_if if_d ();

    assign if_a.start_uart = start && (sel == 0);
    assign if_b.start_uart = start && (sel == 1);
    assign if_c.start_uart = start && (sel == 2);
    assign if_d.start_uart = start && (sel == 3);
    assign if_a.urt_tx_data = data;
    assign if_b.urt_tx_data = data;
    assign if_c.urt_tx_data = data;
    assign if_d.urt_tx_data = data;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_plain (
        .system_clock(system_clock), .rst(rst), .clock_enable(ce), .bus(if_a), .tx_serial(tx_a));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .system_clock(system_clock), .rst(rst), .clock_enable(ce), .bus(if_b), .tx_serial(tx_b));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .system_clock(system_clock), .rst(rst), .clock_enable(ce), .bus(if_c), .tx_serial(tx_c));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
        .system_clock(system_clock), .rst(rst), .clock_enable(ce), .bus(if_d), .tx_serial(tx_d));

    // Observe the instance under test.
    always_comb begin
        tx_m   = tx_a;
        busy_m = if_a.busy_uart;
        done_m = if_a.tx_done;
        case (sel)
            1: begin tx_m = tx_b; busy_m = if_b.busy_uart; done_m = if_b.tx_done; end
            2: begin tx_m = tx_c; busy_m = if_c.busy_uart; done_m = if_c.tx_done; end
            3: begin tx_m = tx_d; busy_m = if_d.busy_uart; done_m = if_d.tx_done; end
            default: ;
        endcase
    end

    always #5 system_clock = ~system_clock;

    // clock_enable: steady high, or alternating every system clock.
    initial begin
        ce = 1'b1;
        forever begin
            @(negedge system_clock);
            ce = ce_toggle ? ~ce : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issue a request and check every cycle of the frame. Entered just after a
    // negedge; returns just after the negedge of the last busy cycle.
    task automatic send_frame(input logic [7:0] b, input int par_en, input logic par_bit,
                              input int stops, input int scale, input bit hold,
                              input bit inject, input int abort_at);
        int   total;
        int   bp;
        logic expb;
        total = (10 + par_en + stops - 1) * CPB * scale;
        data  = b;
        start = 1'b1;
        @(posedge system_clock);
        for (int t = 0; t < total; t++) begin
            @(negedge system_clock);
            #1;
            if (t == abort_at) begin
                rst = 1'b1;
                #1;
                check_eq($sformatf("abort_tx s%0d", sel), 16'(tx_m), 16'd1);
                check_eq($sformatf("abort_busy s%0d", sel), 16'(busy_m), 16'd0);
                check_eq($sformatf("abort_done s%0d", sel), 16'(done_m), 16'd0);
                start = 1'b0;
                return;
            end
            bp = t / (CPB * scale);
            if (bp == 0)                      expb = 1'b0;
            else if (bp <= 8)                 expb = b[bp-1];
            else if (par_en != 0 && bp == 9)  expb = par_bit;
            else                              expb = 1'b1;
            check_eq($sformatf("tx s%0d b%02h t%0d", sel, b, t), 16'(tx_m), 16'(expb));
            check_eq($sformatf("busy s%0d b%02h t%0d", sel, b, t), 16'(busy_m), 16'd1);
            check_eq($sformatf("done s%0d b%02h t%0d", sel, b, t), 16'(done_m), 16'd0);
            if (t == 0 && !hold) start = 1'b0;
            if (inject) begin
                if (t == 5 || t == 20) begin start = 1'b1; data = 8'hFF; end
                if (t == 6 || t == 21) start = 1'b0;
            end
        end
    endtask

    // First cycle after the frame: idle line, busy low, done pulse.
    task automatic check_end();
        @(negedge system_clock);
        #1;
        check_eq($sformatf("end_busy s%0d", sel), 16'(busy_m), 16'd0);
        check_eq($sformatf("end_done s%0d", sel), 16'(done_m), 16'd1);
        check_eq($sformatf("end_tx s%0d", sel), 16'(tx_m), 16'd1);
    endtask

    // After the next enabled edge the done pulse is gone and nothing restarts.
    task automatic check_quiet(input int scale);
        repeat (scale) begin
            @(negedge system_clock);
            #1;
        end
        check_eq($sformatf("quiet_done s%0d", sel), 16'(done_m), 16'd0);
        check_eq($sformatf("quiet_busy s%0d", sel), 16'(busy_m), 16'd0);
        check_eq($sformatf("quiet_tx s%0d", sel), 16'(tx_m), 16'd1);
    endtask

    initial begin
        rst       = 1'b1;
        ce_toggle = 1'b0;
        start     = 1'b0;
        data      = 8'h00;
        sel       = 0;

        // Reset state of every instance.
        @(negedge system_clock);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            check_eq($sformatf("rst_tx s%0d", s), 16'(tx_m), 16'd1);
            check_eq($sformatf("rst_busy s%0d", s), 16'(busy_m), 16'd0);
            check_eq($sformatf("rst_done s%0d", s), 16'(done_m), 16'd0);
        end
        sel = 0;
        rst = 1'b0;
        @(negedge system_clock);
        #1;

        // 0xA5, no parity, one stop: 40 cycles.
        sel = 0;
        send_frame(8'hA5, 0, 1'b0, 1, 1, 1'b0, 1'b0, -1);
        check_end();
        check_quiet(1);

        // 0xA5 with even parity (bit 0) and odd parity (bit 1): 44 cycles.
        sel = 1;
        send_frame(8'hA5, 1, 1'b0, 1, 1, 1'b0, 1'b0, -1);
        check_end();
        check_quiet(1);
        sel = 2;
        send_frame(8'hA5, 1, 1'b1, 1, 1, 1'b0, 1'b0, -1);
        check_end();
        check_quiet(1);

        // Two stop bits, start held: 0x0D then 0x0A with one idle cycle between.
        sel = 3;
        send_frame(8'h0D, 0, 1'b0, 2, 1, 1'b1, 1'b0, -1);
        check_end();
        send_frame(8'h0A, 0, 1'b0, 2, 1, 1'b0, 1'b0, -1);
        check_end();
        check_quiet(1);

        // 0x20 with stray requests and data changes mid-frame.
        sel = 0;
        send_frame(8'h20, 0, 1'b0, 1, 1, 1'b0, 1'b1, -1);
        check_end();
        check_quiet(1);
        check_quiet(1);

        // clock_enable alternating: every bit stretched to 8 system clocks.
        ce_toggle = 1'b1;
        do begin
            @(negedge system_clock);
            #1;
        end while (ce != 1'b1);
        send_frame(8'h41, 0, 1'b0, 1, 2, 1'b0, 1'b0, -1);
        check_end();
        check_quiet(2);
        ce_toggle = 1'b0;
        @(negedge system_clock);
        #1;

        // Reset during data bit 3 aborts; next request is a clean frame.
        send_frame(8'h3C, 0, 1'b0, 1, 1, 1'b0, 1'b0, 17);
        @(negedge system_clock);
        #1;
        check_eq("rst_hold_tx", 16'(tx_m), 16'd1);
        check_eq("rst_hold_busy", 16'(busy_m), 16'd0);
        check_eq("rst_hold_done", 16'(done_m), 16'd0);
        rst = 1'b0;
        send_frame(8'h55, 0, 1'b0, 1, 1, 1'b0, 1'b0, -1);
        check_end();
        check_quiet(1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning enabled clock cycles per serial bit (legal range 2..65535).
REQ-002 Parameter PARITY_EN, default 0, meaning 1 inserts a parity bit after the data bits.
REQ-003 Parameter PARITY_ODD, default 0, meaning 0 selects even parity and 1 selects odd parity; ignored when PARITY_EN=0.
REQ-004 Parameter STOP_BITS, default 1, meaning stop-bit count; legal values are 1 and 2.
REQ-005 system_clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 clock_enable  input  1  qualifies every state, counter and output update; no register changes while low (except reset).
REQ-008 start_uart  input  1  transmit request; sampled only in IDLE.
REQ-009 urt_tx_data  input  8  byte to send; captured on the edge that accepts start_uart.
REQ-010 busy_uart  output  1  high from acceptance of a request until the final stop bit completes.
REQ-011 tx_serial  output  1  serial line; idle high; LSB-first data.
REQ-012 tx_done  output  1  one-enabled-cycle pulse marking frame completion.

Function
REQ-013 FSM states: IDLE, START_BIT, DATA, PARITY, STOP; the FSM SHALL advance only on edges with clock_enable=1.
REQ-014 IDLE: tx_serial=1, busy_uart=0; start_uart=1 on an enabled edge -> latch urt_tx_data into shift register, set busy_uart=1 and tx_serial=0, and enter START_BIT on that same edge.
REQ-015 busy_uart SHALL be registered and visible high on the cycle immediately after the accepting edge, so a requester that pulses start_uart for one cycle and then samples busy_uart never sees a false idle.
REQ-016 A 16-bit baud counter SHALL count 0..CLKS_PER_BIT-1 in each bit state; on terminal count it resets to 0 and the bit ends.
REQ-017 START_BIT: tx_serial=0 for CLKS_PER_BIT enabled cycles -> DATA.
REQ-018 DATA: 3-bit bit index counts 0..7; tx_serial = latched bit[index]; after index 7 completes -> PARITY if PARITY_EN=1, else STOP.
REQ-019 PARITY: tx_serial = XOR of the latched byte, inverted when PARITY_ODD=1; lasts one bit period -> STOP.
REQ-020 STOP: tx_serial=1 for STOP_BITS*CLKS_PER_BIT enabled cycles; on the final terminal count -> IDLE, busy_uart=0, tx_done=1 for that one enabled cycle.
REQ-021 Frame length SHALL be exactly (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT enabled cycles from the accepting edge to busy_uart falling.
REQ-022 start_uart asserted while busy_uart=1 SHALL be ignored, and urt_tx_data changes during a frame SHALL not alter the frame.
REQ-023 start_uart held high through frame end SHALL start the next frame on the first enabled edge in IDLE, giving at least one enabled cycle with busy_uart=0 between frames.
REQ-024 tx_serial SHALL be driven directly from a register (glitch-free, no combinational path from inputs).
REQ-025 clock_enable low mid-frame SHALL freeze the counters and hold tx_serial at its current level, stretching the current bit.

Reset
REQ-026 rst=1 SHALL asynchronously force state=IDLE, tx_serial=1, busy_uart=0, tx_done=0, baud counter=0, bit index=0, shift register=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with tx_serial high and no tx_done pulse; the first request after release SHALL produce a complete, correct frame.

Verification
REQ-028 CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1, clock_enable=1, send 0xA5 -> tx_serial 0,1,0,1,0,0,1,0,1,1 (4 cycles each), busy_uart high 40 cycles, one tx_done pulse.
REQ-029 PARITY_EN=1, send 0xA5: PARITY_ODD=0 -> parity bit 0; PARITY_ODD=1 -> parity bit 1; frame 44 cycles.
REQ-030 STOP_BITS=2, start_uart held high, send 0x0D then 0x0A -> each frame 44 cycles, exactly one idle-high cycle between frames, two tx_done pulses.
REQ-031 start_uart pulsed at cycles 5 and 20 of a 0x20 frame -> ignored; exactly one frame, data unchanged.
REQ-032 clock_enable toggled 1/0 every cycle, send 0x41 -> each bit lasts 8 system clocks; waveform identical to REQ-028 timing scaled by 2.
REQ-033 rst pulsed during DATA bit 3 -> tx_serial=1 and busy_uart=0 the same cycle, no tx_done; a following 0x55 request -> correct 40-cycle frame.
